// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu : MEM-stage load/store unit driving a req/ack word bus
// Revision 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage_lsu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   ALUResultM,
  input  logic [WIDTH-1:0]   WriteDataM,
  input  logic               MemWriteM,
  input  logic [1:0]         ResultSrcM,
  input  logic [2:0]         AddrModeM,
  output logic [WIDTH-1:0]   ReadDataM,
  output logic               StallM,
  output logic               MisalignM,
  output logic               bus_req,
  output logic               bus_we,
  output logic [WIDTH-1:0]   bus_addr,
  output logic [WIDTH-1:0]   bus_wdata,
  output logic [WIDTH/8-1:0] bus_be,
  input  logic [WIDTH-1:0]   bus_rdata,
  input  logic               bus_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic               access;
  logic               misaligned;
  logic               issue;
  logic [1:0]         offset;
  logic [WIDTH-1:0]   store_wdata;
  logic [WIDTH/8-1:0] store_be;
  logic [2:0]         mode_q;
  logic [1:0]         offset_q;
  logic               load_q;
  logic [WIDTH-1:0]   lane;
  logic [WIDTH-1:0]   load_data;

  assign offset = ALUResultM[1:0];
  assign access = MemWriteM | (ResultSrcM == 2'b01);
  assign issue  = (state == S_IDLE) && access && !misaligned;

  // Unknown size encodings behave as full-word accesses.
  always_comb begin
    misaligned = 1'b0;
    case (AddrModeM)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = offset[0];
      default:        misaligned = |offset;
    endcase
  end

  always_comb begin
    store_wdata = WriteDataM;
    store_be    = 4'b1111;
    case (AddrModeM)
      3'b000, 3'b100: begin
        store_wdata = {4{WriteDataM[7:0]}};
        store_be    = 4'b0001 << offset;
      end
      3'b001, 3'b101: begin
        store_wdata = {2{WriteDataM[15:0]}};
        store_be    = 4'b0011 << offset;
      end
      default: begin
        store_wdata = WriteDataM;
        store_be    = 4'b1111;
      end
    endcase
  end

  // Extraction uses the size and offset captured when the request was issued.
  assign lane = bus_rdata >> {offset_q, 3'b000};

  always_comb begin
    load_data = bus_rdata;
    case (mode_q)
      3'b000:  load_data = {{(WIDTH-8){lane[7]}}, lane[7:0]};
      3'b100:  load_data = {{(WIDTH-8){1'b0}}, lane[7:0]};
      3'b001:  load_data = {{(WIDTH-16){lane[15]}}, lane[15:0]};
      3'b101:  load_data = {{(WIDTH-16){1'b0}}, lane[15:0]};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue) begin
          StallM     = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        StallM = 1'b1;
        if (bus_ack) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      ReadDataM <= '0;
      MisalignM <= 1'b0;
      mode_q    <= 3'b000;
      offset_q  <= 2'b00;
      load_q    <= 1'b0;
    end else begin
      state     <= state_next;
      MisalignM <= (state == S_IDLE) && access && misaligned;
      if (issue) begin
        bus_req   <= 1'b1;
        bus_we    <= MemWriteM;
        bus_addr  <= {ALUResultM[WIDTH-1:2], 2'b00};
        bus_wdata <= store_wdata;
        bus_be    <= MemWriteM ? store_be : 4'b1111;
        mode_q    <= AddrModeM;
        offset_q  <= offset;
        load_q    <= !MemWriteM;
      end
      if ((state == S_WAIT) && bus_ack) begin
        bus_req <= 1'b0;
        if (load_q) ReadDataM <= load_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu : scoreboard bench for mem_stage_lsu
// Revision 1.0     : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResultM, WriteDataM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  AddrModeM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  always #5 clk = ~clk;

  mem_stage_lsu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .AddrModeM(AddrModeM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] last_rd;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic ld, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wdata);
    MemWriteM  = we;
    ResultSrcM = ld ? 2'b01 : 2'b00;
    AddrModeM  = mode;
    ALUResultM = addr;
    WriteDataM = wdata;
  endtask

  // Aligned access; waits = number of WAIT cycles, ack arrives in the last one.
  task automatic run_access(input logic we, input logic ld, input logic [2:0] mode,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_rd);
    bus_exp_t    e, cur;
    logic [31:0] rd_exp;
    int          stalls;
    @(posedge clk); #1;
    drive(we, ld, mode, addr, wdata);
    bus_rdata = rdata;
    e.we = we; e.addr = {addr[31:2], 2'b00}; e.wdata = exp_wdata; e.be = exp_be;
    bus_q.push_back(e);
    rd_q.push_back(we ? last_rd : exp_rd);
    stalls = 0;
    cur = e;
    @(negedge clk);
    if (StallM) stalls++;
    check("req_idle", bus_req, 1'b0);
    for (int k = 1; k <= waits; k++) begin
      @(posedge clk); #1;
      if (k == waits) bus_ack = 1'b1;
      @(negedge clk);
      if (StallM) stalls++;
      if (k == 1) cur = bus_q.pop_front();
      check("bus_req", bus_req, 1'b1);
      check("bus_we", bus_we, cur.we);
      check("bus_addr", bus_addr, cur.addr);
      check("bus_be", bus_be, cur.be);
      if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    rd_exp = rd_q.pop_front();
    check("stall_done", StallM, 1'b0);
    check("req_done", bus_req, 1'b0);
    check("read_data", ReadDataM, rd_exp);
    check("stall_cycles", stalls, waits + 1);
    last_rd = rd_exp;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  task automatic run_misalign(input logic we, input logic ld, input logic [2:0] mode,
                              input logic [31:0] addr);
    @(posedge clk); #1;
    drive(we, ld, mode, addr, 32'h1111_2222);
    rd_q.push_back(last_rd);
    @(negedge clk);
    check("mis_stall", StallM, 1'b0);
    check("mis_req0", bus_req, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    @(negedge clk);
    check("mis_pulse", MisalignM, 1'b1);
    check("mis_req1", bus_req, 1'b0);
    check("mis_rdata", ReadDataM, rd_q.pop_front());
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_pulse_end", MisalignM, 1'b0);
  endtask

  task automatic run_reset_mid_wait();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 3'b010, 32'h0000_0108, 32'h0);
    bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("rw_stall", StallM, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rw_req_wait2", bus_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    bus_ack = 1'b1;
    @(negedge clk);
    check("rw_req", bus_req, 1'b0);
    check("rw_stall0", StallM, 1'b0);
    check("rw_rdata", ReadDataM, 32'h0);
    check("rw_be", bus_be, 4'b0000);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    check("rw_late_ack_req", bus_req, 1'b0);
    check("rw_late_ack_stall", StallM, 1'b0);
    check("rw_late_ack_rdata", ReadDataM, 32'h0);
    last_rd = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    last_rd = 32'h0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_req", bus_req, 1'b0);
    check("rst_we", bus_we, 1'b0);
    check("rst_mis", MisalignM, 1'b0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_be", bus_be, 4'b0000);
    check("rst_rdata", ReadDataM, 32'h0);
    check("rst_stall", StallM, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    //          we    ld    mode    addr          wdata         rdata         waits exp_wdata     be       exp_rd
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,        1, 32'hA5A5_A5A5, 4'b1000, 32'h0);
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0,         32'h1234_80FF, 1, 32'h0,        4'b1111, 32'hFFFF_FF80);
    run_access(1'b0, 1'b1, 3'b100, 32'h0000_0101, 32'h0,         32'h1234_80FF, 1, 32'h0,        4'b1111, 32'h0000_0080);
    run_access(1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 4, 32'h0,        4'b1111, 32'h0000_BEEF);
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0,         32'hBEEF_0000, 2, 32'h0,        4'b1111, 32'hFFFF_BEEF);
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0,        1, 32'h1234_1234, 4'b1100, 32'h0);
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_0200, 32'hFFFF_FF3C, 32'h0,        3, 32'h3C3C_3C3C, 4'b0001, 32'h0);
    run_access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0,         32'h7F00_0000, 1, 32'h0,        4'b1111, 32'h0000_007F);
    run_access(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 1, 32'h0,        4'b1111, 32'hCAFE_F00D);
    run_access(1'b1, 1'b1, 3'b010, 32'h0000_010C, 32'h0BAD_F00D, 32'h1357_9BDF, 2, 32'h0BAD_F00D, 4'b1111, 32'h0);

    run_misalign(1'b0, 1'b1, 3'b010, 32'h0000_0102);
    run_misalign(1'b1, 1'b0, 3'b001, 32'h0000_0101);
    run_misalign(1'b0, 1'b1, 3'b111, 32'h0000_0101);

    run_reset_mid_wait();
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_0110, 32'h0,         32'h0000_8001, 1, 32'h0,        4'b1111, 32'hFFFF_8001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
